// File: rtl/vram_controller.sv
// Banked dual-port VRAM with CPU/PPU arbitration and optional general/HBlank DMA.
// Define VRAM_CONTROLLER_HDMA_EN to build the DMA engine (registers FF51-FF55).
module vram_controller #(
    parameter int BANKS = 2,
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [15:0]       cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    input  logic              cpu_wr_i,
    input  logic              cpu_rd_i,
    output logic [7:0]        cpu_rdata_o,
    output logic              cpu_rvalid_o,
    output logic              cpu_stall_o,
    input  logic [1:0]        ppu_mode_i,
    input  logic              ppu_rd_i,
    input  logic [12:0]       ppu_addr_i,
    input  logic [BANK_W-1:0] ppu_bank_i,
    output logic [7:0]        ppu_rdata_o,
    output logic              ppu_rvalid_o,
    output logic              dma_rd_o,
    output logic [15:0]       dma_addr_o,
    input  logic [7:0]        dma_data_i
);
    localparam int MEM_W = BANK_W + 13;
    localparam logic [15:0] ADDR_VBK   = 16'hFF4F;
    localparam logic [15:0] ADDR_HDMA1 = 16'hFF51;
    localparam logic [15:0] ADDR_HDMA2 = 16'hFF52;
    localparam logic [15:0] ADDR_HDMA3 = 16'hFF53;
    localparam logic [15:0] ADDR_HDMA4 = 16'hFF54;
    localparam logic [15:0] ADDR_HDMA5 = 16'hFF55;

    logic [7:0]        mem [0:BANKS*8192-1];
    logic [BANK_W-1:0] vbk_r;
    logic [7:0]        cpu_rdata_r, ppu_rdata_r, reg_rdata_s, vbk_rd_s, ff55_rd_s;
    logic              cpu_rvalid_r, ppu_rvalid_r;
    logic              cpu_vram_s, cpu_reg_s, vram_blocked_s, cpu_vram_we_s, dma_we_s;
    logic [MEM_W-1:0]  cpu_idx_s, ppu_idx_s, dma_idx_s;

    function automatic logic [MEM_W-1:0] mem_index(input logic [BANK_W-1:0] bank,
                                                   input logic [12:0] offs);
        if (BANKS == 1) return {{BANK_W{1'b0}}, offs};
        else            return {bank, offs};
    endfunction

    assign cpu_vram_s     = (cpu_addr_i[15:13] == 3'b100);
    assign cpu_reg_s      = (cpu_addr_i == ADDR_VBK) ||
                            ((cpu_addr_i >= ADDR_HDMA1) && (cpu_addr_i <= ADDR_HDMA5));
    assign vram_blocked_s = (ppu_mode_i == 2'd3);
    assign cpu_idx_s      = mem_index(vbk_r, cpu_addr_i[12:0]);
    assign ppu_idx_s      = mem_index(ppu_bank_i, ppu_addr_i);
    // A DMA write cycle owns port B; a coinciding CPU write is lost.
    assign cpu_vram_we_s  = cpu_wr_i && cpu_vram_s && !vram_blocked_s && !dma_we_s;

    // Register read mux: VBK reads back with unused bits set.
    always_comb begin
        vbk_rd_s = 8'hFF;
        if (BANKS > 1) vbk_rd_s[BANK_W-1:0] = vbk_r;
        else           vbk_rd_s = 8'hFF;
        case (cpu_addr_i)
            ADDR_VBK:   reg_rdata_s = vbk_rd_s;
            ADDR_HDMA5: reg_rdata_s = ff55_rd_s;
            default:    reg_rdata_s = 8'hFF;
        endcase
    end

    // Port B writes; gated during reset so an aborted transfer leaves memory alone.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (dma_we_s)           mem[dma_idx_s] <= dma_data_i;
            else if (cpu_vram_we_s) mem[cpu_idx_s] <= cpu_wdata_i;
        end
    end

    // Port A: PPU fetches are never blocked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ppu_rvalid_r <= 1'b0;
            ppu_rdata_r  <= 8'h00;
        end else begin
            ppu_rvalid_r <= ppu_rd_i;
            if (ppu_rd_i) ppu_rdata_r <= mem[ppu_idx_s];
        end
    end

    // CPU read path and bank select register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_rvalid_r <= 1'b0;
            cpu_rdata_r  <= 8'h00;
            vbk_r        <= '0;
        end else begin
            cpu_rvalid_r <= cpu_rd_i && (cpu_vram_s || cpu_reg_s);
            if (cpu_rd_i) begin
                if (cpu_vram_s) cpu_rdata_r <= vram_blocked_s ? 8'hFF : mem[cpu_idx_s];
                else            cpu_rdata_r <= reg_rdata_s;
            end
            if (cpu_wr_i && (cpu_addr_i == ADDR_VBK) && (BANKS > 1))
                vbk_r <= cpu_wdata_i[BANK_W-1:0];
        end
    end

    assign cpu_rdata_o  = cpu_rdata_r;
    assign cpu_rvalid_o = cpu_rvalid_r;
    assign ppu_rdata_o  = ppu_rdata_r;
    assign ppu_rvalid_o = ppu_rvalid_r;

`ifdef VRAM_CONTROLLER_HDMA_EN
    typedef enum logic [2:0] {S_IDLE, S_GD_RD, S_GD_WR, S_HB_WAIT, S_HB_RD, S_HB_WR} dma_state_t;

    dma_state_t  state_r;
    logic [15:0] src_r, dma_addr_r;
    logic [12:0] dst_r;
    logic [7:0]  blocks_r;
    logic [6:0]  blocks_m1_s;
    logic [3:0]  byte_r;
    logic [1:0]  mode_prev_r;
    logic        cancelled_r, cancel_pend_r, stall_r, dma_rd_r;
    logic        ff55_wr_s, cancel_s, hblank_entry_s, last_byte_s, last_block_s;

    assign ff55_wr_s      = cpu_wr_i && (cpu_addr_i == ADDR_HDMA5);
    assign cancel_s       = ff55_wr_s && !cpu_wdata_i[7];
    assign hblank_entry_s = (ppu_mode_i == 2'd0) && (mode_prev_r != 2'd0);
    assign last_byte_s    = (byte_r == 4'hF);
    assign last_block_s   = (blocks_r == 8'd1);
    assign blocks_m1_s    = blocks_r[6:0] - 7'd1;
    assign dma_we_s       = (state_r == S_GD_WR) || (state_r == S_HB_WR);
    assign dma_idx_s      = mem_index(vbk_r, dst_r);

    // FF55 status: remaining blocks minus one, bit7 marks a cancelled transfer.
    always_comb begin
        if ((state_r == S_HB_WAIT) || (state_r == S_HB_RD) || (state_r == S_HB_WR))
            ff55_rd_s = {1'b0, blocks_m1_s};
        else if ((state_r == S_IDLE) && cancelled_r)
            ff55_rd_s = {1'b1, blocks_m1_s};
        else
            ff55_rd_s = 8'hFF;
    end

    // DMA engine: every byte is one source-read cycle followed by one VRAM write cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= S_IDLE;
            src_r         <= 16'h0000;
            dst_r         <= 13'h0000;
            blocks_r      <= 8'h00;
            byte_r        <= 4'h0;
            mode_prev_r   <= 2'd0;
            cancelled_r   <= 1'b0;
            cancel_pend_r <= 1'b0;
            stall_r       <= 1'b0;
            dma_rd_r      <= 1'b0;
            dma_addr_r    <= 16'h0000;
        end else begin
            mode_prev_r <= ppu_mode_i;
            case (state_r)
                S_IDLE: begin
                    stall_r  <= 1'b0;
                    dma_rd_r <= 1'b0;
                    if (cpu_wr_i) begin
                        case (cpu_addr_i)
                            ADDR_HDMA1: src_r[15:8] <= cpu_wdata_i;
                            ADDR_HDMA2: src_r[7:0]  <= {cpu_wdata_i[7:4], 4'h0};
                            ADDR_HDMA3: dst_r[12:8] <= cpu_wdata_i[4:0];
                            ADDR_HDMA4: dst_r[7:0]  <= {cpu_wdata_i[7:4], 4'h0};
                            ADDR_HDMA5: begin
                                blocks_r      <= {1'b0, cpu_wdata_i[6:0]} + 8'd1;
                                byte_r        <= 4'h0;
                                cancelled_r   <= 1'b0;
                                cancel_pend_r <= 1'b0;
                                if (cpu_wdata_i[7]) begin
                                    state_r <= S_HB_WAIT;
                                end else begin
                                    state_r    <= S_GD_RD;
                                    stall_r    <= 1'b1;
                                    dma_rd_r   <= 1'b1;
                                    dma_addr_r <= src_r;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_GD_RD: begin
                    state_r  <= S_GD_WR;
                    dma_rd_r <= 1'b0;
                end
                S_GD_WR: begin
                    src_r  <= src_r + 16'd1;
                    dst_r  <= dst_r + 13'd1;
                    byte_r <= byte_r + 4'd1;
                    if (last_byte_s) blocks_r <= blocks_r - 8'd1;
                    if (last_byte_s && last_block_s) begin
                        state_r <= S_IDLE;
                        stall_r <= 1'b0;
                    end else begin
                        state_r    <= S_GD_RD;
                        dma_rd_r   <= 1'b1;
                        dma_addr_r <= src_r + 16'd1;
                    end
                end
                S_HB_WAIT: begin
                    if (cancel_s) begin
                        state_r     <= S_IDLE;
                        cancelled_r <= 1'b1;
                    end else if (hblank_entry_s) begin
                        state_r    <= S_HB_RD;
                        stall_r    <= 1'b1;
                        dma_rd_r   <= 1'b1;
                        dma_addr_r <= src_r;
                    end
                end
                S_HB_RD: begin
                    state_r  <= S_HB_WR;
                    dma_rd_r <= 1'b0;
                    if (cancel_s) cancel_pend_r <= 1'b1;
                end
                S_HB_WR: begin
                    src_r  <= src_r + 16'd1;
                    dst_r  <= dst_r + 13'd1;
                    byte_r <= byte_r + 4'd1;
                    if (last_byte_s) blocks_r <= blocks_r - 8'd1;
                    if (last_byte_s && last_block_s) begin
                        state_r <= S_IDLE;
                        stall_r <= 1'b0;
                    end else if (cancel_pend_r || cancel_s) begin
                        state_r       <= S_IDLE;
                        stall_r       <= 1'b0;
                        cancelled_r   <= 1'b1;
                        cancel_pend_r <= 1'b0;
                    end else if (last_byte_s) begin
                        state_r <= S_HB_WAIT;
                        stall_r <= 1'b0;
                    end else begin
                        state_r    <= S_HB_RD;
                        dma_rd_r   <= 1'b1;
                        dma_addr_r <= src_r + 16'd1;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    stall_r  <= 1'b0;
                    dma_rd_r <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_stall_o = stall_r;
    assign dma_rd_o    = dma_rd_r;
    assign dma_addr_o  = dma_addr_r;
`else
    logic unused_dma_s;

    assign unused_dma_s = ^dma_data_i;
    assign dma_we_s     = 1'b0;
    assign dma_idx_s    = '0;
    assign ff55_rd_s    = 8'hFF;
    assign cpu_stall_o  = 1'b0;
    assign dma_rd_o     = 1'b0;
    assign dma_addr_o   = 16'h0000;
`endif
endmodule

// File: tb/tb_vram_controller.sv
// Directed self-checking bench for vram_controller; DMA scenarios build with VRAM_CONTROLLER_HDMA_EN.
module tb_vram_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr, cpu_rd;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid, cpu_stall;
    logic [1:0]  ppu_mode;
    logic        ppu_rd;
    logic [12:0] ppu_addr;
    logic [0:0]  ppu_bank;
    logic [7:0]  ppu_rdata;
    logic        ppu_rvalid;
    logic        dma_rd;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;

    int errors = 0;
    int checks = 0;

    vram_controller #(.BANKS(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_wr_i(cpu_wr), .cpu_rd_i(cpu_rd),
        .cpu_rdata_o(cpu_rdata), .cpu_rvalid_o(cpu_rvalid), .cpu_stall_o(cpu_stall),
        .ppu_mode_i(ppu_mode), .ppu_rd_i(ppu_rd), .ppu_addr_i(ppu_addr), .ppu_bank_i(ppu_bank),
        .ppu_rdata_o(ppu_rdata), .ppu_rvalid_o(ppu_rvalid),
        .dma_rd_o(dma_rd), .dma_addr_o(dma_addr), .dma_data_i(dma_data)
    );

    always #5 clk = ~clk;

    // Source memory model: answers one cycle after dma_rd_o.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8];
    endfunction

    int          dma_rd_count = 0;
    logic [15:0] first_dma_addr = 16'h0000;
    logic [15:0] rd_addr_q;
    always @(posedge clk) begin
        if (dma_rd) begin
            rd_addr_q = dma_addr;
            if (dma_rd_count == 0) first_dma_addr = dma_addr;
            dma_rd_count = dma_rd_count + 1;
            #1 dma_data = src_byte(rd_addr_q);
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output logic v);
        @(posedge clk); #1;
        cpu_addr = a; cpu_rd = 1'b1;
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        d = cpu_rdata; v = cpu_rvalid;
    endtask

    task automatic ppu_read(input logic b, input logic [12:0] a, output logic [7:0] d, output logic v);
        @(posedge clk); #1;
        ppu_bank = b; ppu_addr = a; ppu_rd = 1'b1;
        @(posedge clk); #1;
        ppu_rd = 1'b0;
        d = ppu_rdata; v = ppu_rvalid;
    endtask

    task automatic test_reset;
        logic [7:0] d; logic v;
        #1 rst = 1'b1;
        #2;
        if (cpu_rvalid !== 1'b0) begin $display("FAIL reset_rvalid got=%b exp=0", cpu_rvalid); errors++; end checks++;
        if (cpu_rdata !== 8'h00) begin $display("FAIL reset_rdata got=%h exp=00", cpu_rdata); errors++; end checks++;
        if (ppu_rvalid !== 1'b0) begin $display("FAIL reset_ppu_rvalid got=%b exp=0", ppu_rvalid); errors++; end checks++;
        if (cpu_stall !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", cpu_stall); errors++; end checks++;
        if (dma_rd !== 1'b0) begin $display("FAIL reset_dma_rd got=%b exp=0", dma_rd); errors++; end checks++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cpu_read(16'hFF4F, d, v);
        if (d !== 8'hFE || v !== 1'b1) begin $display("FAIL reset_vbk got=%h/%b exp=fe/1", d, v); errors++; end checks++;
        cpu_read(16'hFF55, d, v);
        if (d !== 8'hFF || v !== 1'b1) begin $display("FAIL reset_ff55 got=%h/%b exp=ff/1", d, v); errors++; end checks++;
    endtask

    task automatic test_bank_select;
        logic [7:0] d; logic v;
        ppu_mode = 2'd1;
        cpu_write(16'h8123, 8'hA5);
        cpu_write(16'hFF4F, 8'h01);
        cpu_read(16'hFF4F, d, v);
        if (d !== 8'hFF) begin $display("FAIL vbk_readback got=%h exp=ff", d); errors++; end checks++;
        cpu_write(16'h8123, 8'h5A);
        cpu_write(16'h9FFF, 8'hC3);
        ppu_read(1'b1, 13'h0123, d, v);
        if (d !== 8'h5A || v !== 1'b1) begin $display("FAIL ppu_bank1 got=%h/%b exp=5a/1", d, v); errors++; end checks++;
        @(posedge clk); #1;
        if (ppu_rvalid !== 1'b0) begin $display("FAIL ppu_rvalid_drop got=%b exp=0", ppu_rvalid); errors++; end checks++;
        ppu_read(1'b0, 13'h0123, d, v);
        if (d !== 8'hA5) begin $display("FAIL ppu_bank0 got=%h exp=a5", d); errors++; end checks++;
        ppu_read(1'b1, 13'h1FFF, d, v);
        if (d !== 8'hC3) begin $display("FAIL ppu_bank1_top got=%h exp=c3", d); errors++; end checks++;
        cpu_read(16'h8123, d, v);
        if (d !== 8'h5A || v !== 1'b1) begin $display("FAIL cpu_bank1 got=%h/%b exp=5a/1", d, v); errors++; end checks++;
    endtask

    task automatic test_mode3;
        logic [7:0] d; logic v;
        cpu_write(16'hFF4F, 8'h00);
        cpu_write(16'h8000, 8'h33);
        ppu_mode = 2'd3;
        cpu_read(16'h8000, d, v);
        if (d !== 8'hFF || v !== 1'b1) begin $display("FAIL mode3_read got=%h/%b exp=ff/1", d, v); errors++; end checks++;
        cpu_write(16'h8000, 8'h11);
        ppu_read(1'b0, 13'h0000, d, v);
        if (d !== 8'h33 || v !== 1'b1) begin $display("FAIL mode3_ppu got=%h/%b exp=33/1", d, v); errors++; end checks++;
        ppu_mode = 2'd1;
        cpu_read(16'h8000, d, v);
        if (d !== 8'h33) begin $display("FAIL mode3_write_dropped got=%h exp=33", d); errors++; end checks++;
    endtask

    task automatic test_no_strobe;
        logic [15:0] addrs [4];
        logic [7:0] d; logic v;
        addrs = '{16'h7FFF, 16'hA000, 16'hFF50, 16'hFF56};
        for (int i = 0; i < 4; i++) begin
            cpu_read(addrs[i], d, v);
            if (v !== 1'b0) begin $display("FAIL no_strobe addr=%h got=%b exp=0", addrs[i], v); errors++; end checks++;
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 16'h8200 + 16'(i); cpu_wdata = 8'h10 + 8'(i); cpu_wr = 1'b1;
            @(posedge clk); #1;
        end
        cpu_wr = 1'b0;
        cpu_addr = 16'h8200; cpu_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (cpu_rdata !== 8'h10 + 8'(i) || cpu_rvalid !== 1'b1) begin
                $display("FAIL b2b_read%0d got=%h/%b exp=%h/1", i, cpu_rdata, cpu_rvalid, 8'h10 + 8'(i)); errors++;
            end
            checks++;
            if (i < 3) cpu_addr = 16'h8201 + 16'(i);
            else       cpu_rd = 1'b0;
        end
    endtask

`ifdef VRAM_CONTROLLER_HDMA_EN
    task automatic test_gdma;
        logic [7:0] d; logic v;
        int n, rd_start;
        cpu_write(16'hFF51, 8'hC0);
        cpu_write(16'hFF52, 8'h0F);
        cpu_write(16'hFF53, 8'h1F);
        cpu_write(16'hFF54, 8'hF0);
        rd_start = dma_rd_count;
        cpu_write(16'hFF55, 8'h01);
        n = 0;
        while (cpu_stall === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
        if (n !== 64) begin $display("FAIL gdma_stall_cycles got=%0d exp=64", n); errors++; end checks++;
        if (dma_rd_count - rd_start !== 32) begin $display("FAIL gdma_reads got=%0d exp=32", dma_rd_count - rd_start); errors++; end checks++;
        if (first_dma_addr !== 16'hC000) begin $display("FAIL gdma_first_src got=%h exp=c000", first_dma_addr); errors++; end checks++;
        ppu_read(1'b0, 13'h1FF0, d, v);
        if (d !== 8'h9A) begin $display("FAIL gdma_dst_1ff0 got=%h exp=9a", d); errors++; end checks++;
        ppu_read(1'b0, 13'h1FFF, d, v);
        if (d !== 8'h95) begin $display("FAIL gdma_dst_1fff got=%h exp=95", d); errors++; end checks++;
        ppu_read(1'b0, 13'h0000, d, v);
        if (d !== 8'h8A) begin $display("FAIL gdma_wrap_0000 got=%h exp=8a", d); errors++; end checks++;
        ppu_read(1'b0, 13'h000F, d, v);
        if (d !== 8'h85) begin $display("FAIL gdma_wrap_000f got=%h exp=85", d); errors++; end checks++;
        cpu_read(16'hFF55, d, v);
        if (d !== 8'hFF) begin $display("FAIL gdma_ff55_done got=%h exp=ff", d); errors++; end checks++;
    endtask

    task automatic test_hdma;
        logic [7:0] d, exp_d; logic v;
        int n;
        ppu_mode = 2'd2;
        cpu_write(16'hFF4F, 8'h01);
        cpu_write(16'hFF51, 8'h40);
        cpu_write(16'hFF52, 8'h00);
        cpu_write(16'hFF53, 8'h01);
        cpu_write(16'hFF54, 8'h00);
        cpu_write(16'hFF55, 8'h82);
        cpu_read(16'hFF55, d, v);
        if (d !== 8'h02) begin $display("FAIL hdma_ff55_start got=%h exp=02", d); errors++; end checks++;
        if (cpu_stall !== 1'b0) begin $display("FAIL hdma_wait_stall got=%b exp=0", cpu_stall); errors++; end checks++;
        for (int blk = 0; blk < 3; blk++) begin
            @(posedge clk); #1 ppu_mode = 2'd0;
            @(posedge clk); #1;
            n = 0;
            if (blk == 0) begin
                ppu_mode = 2'd2; n = 1;
                @(posedge clk); #1 ppu_mode = 2'd0;
            end
            while (cpu_stall === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
            if (n !== 32) begin $display("FAIL hdma_block%0d_stall got=%0d exp=32", blk, n); errors++; end checks++;
            exp_d = (blk == 0) ? 8'h01 : (blk == 1) ? 8'h00 : 8'hFF;
            cpu_read(16'hFF55, d, v);
            if (d !== exp_d) begin $display("FAIL hdma_block%0d_ff55 got=%h exp=%h", blk, d, exp_d); errors++; end checks++;
            ppu_mode = 2'd2;
        end
        ppu_read(1'b1, 13'h0100, d, v);
        if (d !== 8'h1A) begin $display("FAIL hdma_data_first got=%h exp=1a", d); errors++; end checks++;
        ppu_read(1'b1, 13'h012F, d, v);
        if (d !== 8'h35) begin $display("FAIL hdma_data_last got=%h exp=35", d); errors++; end checks++;
    endtask

    task automatic test_hdma_cancel;
        logic [7:0] d; logic v;
        ppu_mode = 2'd2;
        cpu_write(16'hFF4F, 8'h00);
        cpu_write(16'h8403, 8'hEE);
        cpu_write(16'hFF51, 8'h20);
        cpu_write(16'hFF52, 8'h00);
        cpu_write(16'hFF53, 8'h04);
        cpu_write(16'hFF54, 8'h00);
        cpu_write(16'hFF55, 8'h83);
        @(posedge clk); #1 ppu_mode = 2'd0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        cpu_write(16'hFF55, 8'h00);
        if (cpu_stall !== 1'b1) begin $display("FAIL cancel_finish_byte got=%b exp=1", cpu_stall); errors++; end checks++;
        @(posedge clk); #1;
        if (cpu_stall !== 1'b0) begin $display("FAIL cancel_stop got=%b exp=0", cpu_stall); errors++; end checks++;
        cpu_read(16'hFF55, d, v);
        if (d !== 8'h83) begin $display("FAIL cancel_ff55 got=%h exp=83", d); errors++; end checks++;
        ppu_read(1'b0, 13'h0400, d, v);
        if (d !== 8'h7A) begin $display("FAIL cancel_byte0 got=%h exp=7a", d); errors++; end checks++;
        ppu_read(1'b0, 13'h0402, d, v);
        if (d !== 8'h78) begin $display("FAIL cancel_byte2 got=%h exp=78", d); errors++; end checks++;
        ppu_read(1'b0, 13'h0403, d, v);
        if (d !== 8'hEE) begin $display("FAIL cancel_byte3_untouched got=%h exp=ee", d); errors++; end checks++;
        ppu_mode = 2'd1;
    endtask
`else
    task automatic test_hdma_disabled;
        logic [7:0] d; logic v;
        int busy;
        cpu_write(16'hFF51, 8'hC0);
        cpu_write(16'hFF55, 8'h01);
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (cpu_stall !== 1'b0 || dma_rd !== 1'b0) busy++;
        end
        if (busy !== 0) begin $display("FAIL nodma_idle busy_cycles=%0d exp=0", busy); errors++; end checks++;
        if (dma_addr !== 16'h0000) begin $display("FAIL nodma_addr got=%h exp=0000", dma_addr); errors++; end checks++;
        cpu_read(16'hFF55, d, v);
        if (d !== 8'hFF || v !== 1'b1) begin $display("FAIL nodma_ff55 got=%h/%b exp=ff/1", d, v); errors++; end checks++;
        cpu_read(16'hFF51, d, v);
        if (d !== 8'hFF || v !== 1'b1) begin $display("FAIL nodma_ff51 got=%h/%b exp=ff/1", d, v); errors++; end checks++;
    endtask
`endif

    task automatic test_reset_pulse;
        logic [7:0] d; logic v;
        ppu_mode = 2'd1;
        cpu_write(16'hFF4F, 8'h01);
`ifdef VRAM_CONTROLLER_HDMA_EN
        cpu_write(16'hFF55, 8'h00);
        repeat (5) @(posedge clk);
        if (cpu_stall !== 1'b1) begin $display("FAIL rst_gdma_running got=%b exp=1", cpu_stall); errors++; end checks++;
`else
        repeat (2) @(posedge clk);
`endif
        #2 rst = 1'b1;
        #1;
        if (cpu_stall !== 1'b0) begin $display("FAIL rst_async_stall got=%b exp=0", cpu_stall); errors++; end checks++;
        if (dma_rd !== 1'b0) begin $display("FAIL rst_async_dma_rd got=%b exp=0", dma_rd); errors++; end checks++;
        #1 rst = 1'b0;
        cpu_read(16'hFF55, d, v);
        if (d !== 8'hFF) begin $display("FAIL rst_ff55 got=%h exp=ff", d); errors++; end checks++;
        cpu_read(16'hFF4F, d, v);
        if (d !== 8'hFE) begin $display("FAIL rst_vbk got=%h exp=fe", d); errors++; end checks++;
        if (cpu_stall !== 1'b0) begin $display("FAIL rst_stall_after got=%b exp=0", cpu_stall); errors++; end checks++;
    endtask

    initial begin
        rst = 1'b0;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
        ppu_mode = 2'd1; ppu_rd = 1'b0; ppu_addr = 13'h0000; ppu_bank = 1'b0;
        dma_data = 8'h00;
        test_reset();
        test_bank_select();
        test_mode3();
        test_no_strobe();
        test_back_to_back();
`ifdef VRAM_CONTROLLER_HDMA_EN
        test_gdma();
        test_hdma();
        test_hdma_cancel();
`else
        test_hdma_disabled();
`endif
        test_reset_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
